soc_sysid_ext: RTL and testbench

//  Parametrised system-ID/info slave on the SoC Avalon-MM fabric. Adds version word, user build words,

---
 rtl/soc_sysid_pkg.sv | 19 +
 rtl/soc_sysid_uptime.sv | 56 +++++
 rtl/soc_sysid_ext.sv | 127 ++++++++++++
 tb/tb_soc_sysid_ext.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_sysid_pkg.sv
// rtl/soc_sysid_pkg.sv - word map, CONTROL and feature bit indices for soc_sysid_ext
package soc_sysid_pkg;

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_VERSION   = 4'd2;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd4;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd5;
    localparam logic [3:0] ADDR_CONTROL   = 4'd6;
    localparam logic [3:0] ADDR_RSVD      = 4'd7;
    localparam logic [3:0] ADDR_USER0     = 4'd8;

    localparam int CTRL_CLR    = 0;
    localparam int CTRL_FREEZE = 1;

    localparam int FEAT_SCRATCH = 0;

endpackage

// File: rtl/soc_sysid_uptime.sv
// rtl/soc_sysid_uptime.sv - prescaled free-running uptime counter with clear and freeze
//
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset
//   clr_i           zero counter and prescaler at the next edge (wins over increment)
//   freeze_i        hold counter and prescaler
//   count_o         counter zero-extended to 64 bits
module soc_sysid_uptime #(
    parameter int UPTIME_W = 64,
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        freeze_i,
    output logic [63:0] count_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [UPTIME_W-1:0] cnt_q, cnt_d;
    logic                tick;

    // With PRESCALE=1 the prescaler stays at 0 and every clock is a tick.
    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (!freeze_i) begin
            if (tick) begin
                pre_d = '0;
                cnt_d = cnt_q + UPTIME_W'(1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = 64'(cnt_q);

endmodule

// File: rtl/soc_sysid_ext.sv
// rtl/soc_sysid_ext.sv - system-ID/info slave: ID, timestamp, version, uptime, scratch, control, user words
//
// Optional feature macro: SOC_SYSID_SCRATCH_EN (word 5 becomes a 32-bit RW scratch register).
//
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   address          word address
//   read, write      access strobes, always accepted in the same cycle
//   writedata        write data
//   user_word        NUM_USER static build words, word k at [32k+31:32k]
//   readdata         registered read data, holds while readdatavalid is low
//   readdatavalid    one cycle after an accepted read
module soc_sysid_ext
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h65FA_4A53,
    parameter logic [7:0]  VER_MAJOR = 8'd2,
    parameter logic [7:0]  VER_MINOR = 8'd0,
    parameter int          NUM_USER  = 4,
    parameter int          UPTIME_W  = 64,
    parameter int          PRESCALE  = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [NUM_USER*32-1:0] user_word,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

`ifdef SOC_SYSID_SCRATCH_EN
    localparam logic [7:0] FEAT = 8'(1 << FEAT_SCRATCH);
`else
    localparam logic [7:0] FEAT = 8'h00;
`endif

    localparam logic [31:0] VERSION = {VER_MAJOR, VER_MINOR, 8'(NUM_USER), FEAT};

    logic [63:0] count;
    logic [31:0] shadow_q;
    logic        freeze_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic        ctrl_wr;
    logic        clr;
    logic        unused_wdata;

    assign ctrl_wr      = write && (address == ADDR_CONTROL);
    // CLR is a pulse taken straight off the bus; it is never stored.
    assign clr          = ctrl_wr && writedata[CTRL_CLR];
    assign unused_wdata = ^writedata[31:2];

    soc_sysid_uptime #(
        .UPTIME_W (UPTIME_W),
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (clr),
        .freeze_i (freeze_q),
        .count_o  (count)
    );

`ifdef SOC_SYSID_SCRATCH_EN
    logic [31:0] scratch_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch_q <= '0;
        end else if (write && (address == ADDR_SCRATCH)) begin
            scratch_q <= writedata;
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_ID:        rdata_d = SYSTEM_ID;
            ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
            ADDR_VERSION:   rdata_d = VERSION;
            ADDR_UPTIME_LO: rdata_d = count[31:0];
            ADDR_UPTIME_HI: rdata_d = shadow_q;
`ifdef SOC_SYSID_SCRATCH_EN
            ADDR_SCRATCH:   rdata_d = scratch_q;
`endif
            ADDR_CONTROL:   rdata_d[CTRL_FREEZE] = freeze_q;
            ADDR_RSVD:      rdata_d = '0;
            default: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    if (address == ADDR_USER0 + 4'(k)) begin
                        rdata_d = user_word[k*32 +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            shadow_q <= '0;
            freeze_q <= 1'b0;
        end else begin
            rvalid_q <= read;
            if (read) begin
                rdata_q <= rdata_d;
            end
            // Latching the high half on a LO read makes the LO/HI pair coherent.
            if (read && (address == ADDR_UPTIME_LO)) begin
                shadow_q <= count[63:32];
            end
            if (ctrl_wr) begin
                freeze_q <= writedata[CTRL_FREEZE];
            end
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_soc_sysid_ext.sv
// tb/tb_soc_sysid_ext.sv - scoreboard testbench for soc_sysid_ext
module tb_soc_sysid_ext;

`ifdef SOC_SYSID_SCRATCH_EN
    localparam logic [31:0] EXP_VERSION = 32'h0200_0401;
    localparam logic [31:0] EXP_SCRATCH = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] EXP_VERSION = 32'h0200_0400;
    localparam logic [31:0] EXP_SCRATCH = 32'h0000_0000;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic [3:0]   addr = 4'd0;
    logic [31:0]  wdata = 32'd0;
    logic [127:0] user_word = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    logic [31:0]  readdata;
    logic         readdatavalid;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic        exp_vld = 1'b0;
    logic        exp_rst = 1'b0;
    logic [31:0] last_rd = 32'd0;

    int          ref_pre = 0;
    logic [63:0] ref_cnt = 64'd0;
    logic        ref_freeze = 1'b0;

    always #5 clk = ~clk;

    soc_sysid_ext #(
        .SYSTEM_ID (32'hC0DE_0001),
        .TIMESTAMP (32'h65FA_4A53),
        .VER_MAJOR (8'd2),
        .VER_MINOR (8'd0),
        .NUM_USER  (4),
        .UPTIME_W  (64),
        .PRESCALE  (4)
    ) dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .address       (addr),
        .read          (rd),
        .write         (wr),
        .writedata     (wdata),
        .user_word     (user_word),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    // Reference uptime counter with PRESCALE=4.
    always @(posedge clk) begin
        if (!reset_n) begin
            ref_pre    <= 0;
            ref_cnt    <= 64'd0;
            ref_freeze <= 1'b0;
        end else begin
            if (wr && addr == 4'd6) ref_freeze <= wdata[1];
            if (wr && addr == 4'd6 && wdata[0]) begin
                ref_pre <= 0;
                ref_cnt <= 64'd0;
            end else if (!ref_freeze) begin
                if (ref_pre == 3) begin
                    ref_pre <= 0;
                    ref_cnt <= ref_cnt + 64'd1;
                end else begin
                    ref_pre <= ref_pre + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        exp_vld <= rd && reset_n;
        exp_rst <= !reset_n;
    end

    // Monitor: latency of readdatavalid, data against scoreboard, hold when idle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (exp_rst) last_rd = 32'd0;
        checks++;
        if (readdatavalid !== exp_vld) begin
            failures++;
            $display("FAIL rdvalid actual=%b required=%b t=%0t", readdatavalid, exp_vld, $time);
        end
        if (readdatavalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read actual=%h required=none t=%0t", readdata, $time);
            end else begin
                e = exp_q.pop_front();
                if (readdata !== e) begin
                    failures++;
                    $display("FAIL readdata actual=%h required=%h t=%0t", readdata, e, $time);
                end
                last_rd = e;
            end
        end else begin
            checks++;
            if (readdata !== last_rd) begin
                failures++;
                $display("FAIL readdata_hold actual=%h required=%h t=%0t", readdata, last_rd, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rd = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 32'd0;
        end
    endtask

    task automatic wr_(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    endtask

    task automatic rdx(input logic [3:0] a, input logic [31:0] expv);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = a; wdata = 32'd0;
        exp_q.push_back(expv);
    endtask

    task automatic rd_lo_model();
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 4'd3; wdata = 32'd0;
        exp_q.push_back(ref_cnt[31:0]);
    endtask

    initial begin
        idle(3);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_rdvalid", {31'd0, readdatavalid}, 32'd0);

        // Release reset, then 39 idle cycles: LO read sampled after 40 counting clocks.
        @(negedge clk);
        reset_n = 1'b1;
        idle(39);
        rdx(4'd3, 32'd10);
        rdx(4'd4, 32'd0);
        idle(1);

        rdx(4'd0, 32'hC0DE_0001);
        rdx(4'd1, 32'h65FA_4A53);
        rdx(4'd2, EXP_VERSION);

        for (int k = 0; k < 4; k++) rdx(4'(8 + k), user_word[k*32 +: 32]);
        for (int k = 12; k < 16; k++) rdx(4'(k), 32'd0);
        rdx(4'd7, 32'd0);
        rdx(4'd6, 32'd0);

        // Simultaneous read and write of scratch returns the old value.
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 4'd5; wdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'd0);
        rdx(4'd5, EXP_SCRATCH);
        wr_(4'd0, 32'hFFFF_FFFF);
        rdx(4'd0, 32'hC0DE_0001);
        idle(2);

        // Freeze holds the counter; CLR with freeze zeroes it and stays frozen.
        wr_(4'd6, 32'd2);
        rd_lo_model();
        idle(20);
        rd_lo_model();
        wr_(4'd6, 32'd3);
        rdx(4'd3, 32'd0);
        idle(10);
        rdx(4'd3, 32'd0);
        rdx(4'd6, 32'd2);

        // Carry across the 32-bit boundary: pair read straddling the carry stays coherent.
        idle(1);
        force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
        idle(1);
        release dut.u_uptime.cnt_q;
        wr_(4'd6, 32'd0);
        rdx(4'd3, 32'hFFFF_FFFF);
        idle(4);
        rdx(4'd4, 32'd0);
        rdx(4'd3, 32'd0);
        rdx(4'd4, 32'd1);
        idle(2);

        // Read issued while reset is low is dropped.
        @(negedge clk);
        reset_n = 1'b0; rd = 1'b1; wr = 1'b0; addr = 4'd1;
        idle(1);
        chk("rst_mid_rdvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_mid_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        rdx(4'd0, 32'hC0DE_0001);
        rdx(4'd6, 32'd0);
        rdx(4'd5, 32'd0);
        idle(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
